// File: rtl/load_buffer_tracker.sv
// Load buffer tracker: allocates entry indices for in-flight loads and returns their metadata on response.
// Build option: LOAD_BUFFER_TRACKER_OOO_EN selects out-of-order completion; undefined gives an in-order FIFO.
module load_buffer_tracker #(
  parameter int NR_ENTRIES    = 2,
  parameter int TRANS_ID_BITS = 3,
  parameter int OFFSET_BITS   = 3,
  parameter int IDX_W         = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
  parameter int CNT_W         = $clog2(NR_ENTRIES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     alloc_valid_i,
  output logic                     alloc_ready_o,
  input  logic [TRANS_ID_BITS-1:0] alloc_trans_id_i,
  input  logic [OFFSET_BITS-1:0]   alloc_offset_i,
  input  logic [1:0]               alloc_size_i,
  input  logic                     alloc_sign_i,
  output logic [IDX_W-1:0]         alloc_idx_o,
  input  logic                     rsp_valid_i,
  input  logic [IDX_W-1:0]         rsp_idx_i,
  output logic                     done_valid_o,
  output logic [TRANS_ID_BITS-1:0] done_trans_id_o,
  output logic [OFFSET_BITS-1:0]   done_offset_o,
  output logic [1:0]               done_size_o,
  output logic                     done_sign_o,
  output logic                     error_o,
  output logic [CNT_W-1:0]         occupancy_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  logic [NR_ENTRIES-1:0]    used;
  logic [NR_ENTRIES-1:0]    killed;
  logic [TRANS_ID_BITS-1:0] transIdMem [NR_ENTRIES];
  logic [OFFSET_BITS-1:0]   offsetMem  [NR_ENTRIES];
  logic [1:0]               sizeMem    [NR_ENTRIES];
  logic                     signMem    [NR_ENTRIES];

  logic             allocFree;
  logic             allocFire;
  logic [IDX_W-1:0] allocIdx;
  logic             rspInRange;
  logic             rspOrderOk;
  logic             rspAccept;
  logic             rspLive;
  logic             rspErr;

  // Non-power-of-two sizes leave index codes that map to no entry.
  if (NR_ENTRIES == (1 << IDX_W)) begin : g_pow2
    assign rspInRange = 1'b1;
  end else begin : g_npow2
    assign rspInRange = (rsp_idx_i <= LAST_IDX);
  end

`ifdef LOAD_BUFFER_TRACKER_OOO_EN
  always_comb begin
    allocIdx = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!used[i]) allocIdx = IDX_W'(i);
    end
  end
  assign allocFree  = |(~used);
  assign rspOrderOk = 1'b1;
`else
  logic [IDX_W-1:0] wrPtr;
  logic [IDX_W-1:0] rdPtr;

  function automatic logic [IDX_W-1:0] nextPtr(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // In FIFO order the write slot is free exactly when any slot is free.
  assign allocIdx   = wrPtr;
  assign allocFree  = !used[wrPtr];
  assign rspOrderOk = (rsp_idx_i == rdPtr);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (allocFire) wrPtr <= nextPtr(wrPtr);
      if (rspAccept) rdPtr <= nextPtr(rdPtr);
    end
  end
`endif

  assign alloc_ready_o = !flush_i && allocFree;
  assign alloc_idx_o   = allocIdx;
  assign allocFire     = alloc_valid_i && alloc_ready_o;

  assign rspAccept = rsp_valid_i && rspInRange && used[rsp_idx_i] && rspOrderOk;
  assign rspErr    = rsp_valid_i && !rspAccept;
  // A response landing in the flush cycle belongs to a killed load.
  assign rspLive   = rspAccept && !killed[rsp_idx_i] && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used            <= '0;
      killed          <= '0;
      done_valid_o    <= 1'b0;
      done_trans_id_o <= '0;
      done_offset_o   <= '0;
      done_size_o     <= '0;
      done_sign_o     <= 1'b0;
      error_o         <= 1'b0;
      occupancy_o     <= '0;
    end else begin
      error_o      <= rspErr;
      done_valid_o <= rspLive;
      if (rspLive) begin
        done_trans_id_o <= transIdMem[rsp_idx_i];
        done_offset_o   <= offsetMem[rsp_idx_i];
        done_size_o     <= sizeMem[rsp_idx_i];
        done_sign_o     <= signMem[rsp_idx_i];
      end
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (flush_i && used[i]) killed[i] <= 1'b1;
        if (rspAccept && rsp_idx_i == IDX_W'(i)) begin
          used[i]   <= 1'b0;
          killed[i] <= 1'b0;
        end
        if (allocFire && allocIdx == IDX_W'(i)) begin
          used[i]   <= 1'b1;
          killed[i] <= 1'b0;
        end
      end
      occupancy_o <= occupancy_o + CNT_W'(allocFire) - CNT_W'(rspAccept);
    end
  end

  always_ff @(posedge clk_i) begin
    if (allocFire) begin
      transIdMem[allocIdx] <= alloc_trans_id_i;
      offsetMem[allocIdx]  <= alloc_offset_i;
      sizeMem[allocIdx]    <= alloc_size_i;
      signMem[allocIdx]    <= alloc_sign_i;
    end
  end

endmodule
